// File: rtl/dmac_req_arbiter.sv
// Multi-channel DMA request arbiter and AHB bus-ownership sequencer (fixed or round-robin).
// Optional REQ-phase grant-wait timeout is built in when DMAC_ARB_TIMEOUT_EN is defined.
module dmac_req_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int ARB_MODE    = 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] DmacReq,
  input  logic [NUM_CH-1:0] Ch_En,
  input  logic              Bus_Grant,
  input  logic              Ch_Done,
  input  logic              Ch_Err,
  input  logic [NUM_CH-1:0] Irq_Clr,
  output logic              Bus_Req,
  output logic [NUM_CH-1:0] Ch_Grant,
  output logic              Ch_Start,
  output logic              Ch_Hold,
  output logic [NUM_CH-1:0] ReqAck,
  output logic [NUM_CH-1:0] Irq_Status,
  output logic [NUM_CH-1:0] Err_Status,
  output logic              Interrupt
);

  localparam int                PW   = $clog2(NUM_CH);
  localparam logic [PW:0]       NCH  = (PW+1)'(NUM_CH);
  localparam logic [PW-1:0]     LAST = PW'(NUM_CH-1);
  localparam logic [NUM_CH-1:0] ONE  = {{(NUM_CH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic [NUM_CH-1:0] irq_q, irq_d;
  logic [NUM_CH-1:0] err_q, err_d;
  logic [PW-1:0]     cur_q, cur_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic              bus_req_q, bus_req_d;
  logic              start_q, start_d;
  logic              int_q, int_d;

  logic [NUM_CH-1:0] elig_s;
  logic [NUM_CH-1:0] set_irq_s;
  logic [NUM_CH-1:0] set_err_s;
  logic [PW:0]       win_s;
  logic              win_vld_s;
  logic [PW-1:0]     win_idx_s;
  logic [PW-1:0]     ptr_next_s;

  // Returns {found, index} of the first set bit of elig at or after ptr, wrapping.
  function automatic logic [PW:0] pick_winner(input logic [NUM_CH-1:0] elig,
                                              input logic [PW-1:0]     ptr);
    logic [PW:0] res;
    logic [PW:0] idx;
    res = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + k[PW:0];
      if (idx >= NCH) begin
        idx = idx - NCH;
      end else begin
        idx = idx;
      end
      if (elig[idx[PW-1:0]]) begin
        res = {1'b1, idx[PW-1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // A channel with pending status is held off until software clears it.
  assign elig_s    = DmacReq & Ch_En & ~irq_q;
  assign win_s     = pick_winner(elig_s, (ARB_MODE == 0) ? {PW{1'b0}} : ptr_q);
  assign win_vld_s = win_s[PW];
  assign win_idx_s = win_s[PW-1:0];
  assign ptr_next_s = (cur_q == LAST) ? {PW{1'b0}} : (cur_q + {{(PW-1){1'b0}}, 1'b1});

`ifdef DMAC_ARB_TIMEOUT_EN
  localparam int            CW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_s;
  assign tmo_s = (cnt_q == TO_LAST);
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYC > 0);
`endif

  // Next-state and next-output computation for the sequencer and status flags.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cur_d     = cur_q;
    ptr_d     = ptr_q;
    bus_req_d = bus_req_q;
    start_d   = 1'b0;
    ack_d     = '0;
    set_irq_s = '0;
    set_err_s = '0;
`ifdef DMAC_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_vld_s) begin
          state_d   = ST_REQ;
          grant_d   = ONE << win_idx_s;
          cur_d     = win_idx_s;
          bus_req_d = 1'b1;
`ifdef DMAC_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (Bus_Grant) begin
          state_d = ST_XFER;
          start_d = 1'b1;
`ifdef DMAC_ARB_TIMEOUT_EN
        end else if (tmo_s) begin
          // Abandon the request: flag the channel as errored but never acknowledge it.
          state_d   = ST_IDLE;
          set_irq_s = grant_q;
          set_err_s = grant_q;
          bus_req_d = 1'b0;
          grant_d   = '0;
          ptr_d     = ptr_next_s;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
`else
        end else begin
          state_d = ST_REQ;
        end
`endif
      end
      ST_XFER: begin
        if (Ch_Err || Ch_Done) begin
          state_d   = ST_DONE;
          ack_d     = grant_q;
          set_irq_s = grant_q;
          set_err_s = Ch_Err ? grant_q : '0;
          bus_req_d = 1'b0;
          grant_d   = '0;
          ptr_d     = ptr_next_s;
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        grant_d   = '0;
        bus_req_d = 1'b0;
      end
    endcase
    irq_d = (irq_q & ~Irq_Clr) | set_irq_s;
    err_d = (err_q & ~Irq_Clr) | set_err_s;
    int_d = |irq_d;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      ack_q     <= '0;
      irq_q     <= '0;
      err_q     <= '0;
      cur_q     <= '0;
      ptr_q     <= '0;
      bus_req_q <= 1'b0;
      start_q   <= 1'b0;
      int_q     <= 1'b0;
`ifdef DMAC_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      irq_q     <= irq_d;
      err_q     <= err_d;
      cur_q     <= cur_d;
      ptr_q     <= ptr_d;
      bus_req_q <= bus_req_d;
      start_q   <= start_d;
      int_q     <= int_d;
`ifdef DMAC_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign Bus_Req    = bus_req_q;
  assign Ch_Grant   = grant_q;
  assign Ch_Start   = start_q;
  assign ReqAck     = ack_q;
  assign Irq_Status = irq_q;
  assign Err_Status = err_q;
  assign Interrupt  = int_q;
  // Stall follows the live grant so the engine freezes in the same cycle the bus is lost.
  assign Ch_Hold    = (state_q == ST_XFER) & ~Bus_Grant;

endmodule
